// File: rtl/l1_d_if.sv
// Bundles the pipeline load/store port, the LLC fill/write-through port and the snoop
// channel of the L1 data cache. The cache uses the slave view; the environment uses master.
interface l1_d_if;
    logic [63:0]  S_R_ADDR;
    logic         S_R_ADDR_VALID;
    logic [63:0]  S_R_DATA;
    logic         S_R_DATA_VALID;
    logic         S_W_VALID;
    logic [63:0]  S_W_ADDR;
    logic [63:0]  S_W_DATA;
    logic [3:0]   S_W_SIZE;
    logic         S_W_READY;
    logic         S_W_COMPLETE;
    logic [63:0]  L2_S_R_ADDR;
    logic         L2_S_R_ADDR_VALID;
    logic [511:0] L2_S_R_DATA;
    logic         L2_S_R_DATA_VALID;
    logic         L2_S_W_VALID;
    logic [63:0]  L2_S_W_ADDR;
    logic [511:0] L2_S_W_DATA;
    logic         L2_S_W_READY;
    logic         L2_S_W_COMPLETE;
    logic         m_axi_acvalid;
    logic [63:0]  m_axi_acaddr;
    logic [3:0]   m_axi_acsnoop;

    modport slave (
        input  S_R_ADDR, S_R_ADDR_VALID, S_W_VALID, S_W_ADDR, S_W_DATA, S_W_SIZE,
        input  L2_S_R_DATA, L2_S_R_DATA_VALID, L2_S_W_READY, L2_S_W_COMPLETE,
        input  m_axi_acvalid, m_axi_acaddr, m_axi_acsnoop,
        output S_R_DATA, S_R_DATA_VALID, S_W_READY, S_W_COMPLETE,
        output L2_S_R_ADDR, L2_S_R_ADDR_VALID, L2_S_W_VALID, L2_S_W_ADDR, L2_S_W_DATA
    );

    modport master (
        output S_R_ADDR, S_R_ADDR_VALID, S_W_VALID, S_W_ADDR, S_W_DATA, S_W_SIZE,
        output L2_S_R_DATA, L2_S_R_DATA_VALID, L2_S_W_READY, L2_S_W_COMPLETE,
        output m_axi_acvalid, m_axi_acaddr, m_axi_acsnoop,
        input  S_R_DATA, S_R_DATA_VALID, S_W_READY, S_W_COMPLETE,
        input  L2_S_R_ADDR, L2_S_R_ADDR_VALID, L2_S_W_VALID, L2_S_W_ADDR, L2_S_W_DATA
    );
endinterface

// File: rtl/l1_d.sv
// Direct-mapped 4 KiB write-allocate, write-through L1 data cache (64 sets x 64 B lines)
// with line fills from the LLC and MakeInvalid snoop handling.
module l1_d (
    input  logic  clk,
    input  logic  reset,
    l1_d_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, RD_FILL, RD_RESP, WR_FILL, WR_SEND, WR_WAIT, WR_DONE
    } state_t;

    localparam logic [3:0] MAKE_INVALID = 4'b1101;

    state_t       state_reg;
    logic [511:0] data_mem [64];
    logic [51:0]  tag_mem [64];
    logic [63:0]  valid_reg;
    logic [63:0]  addr_reg;
    logic [63:0]  wdata_reg;
    logic [3:0]   wsize_reg;

    // Eight bytes starting at the offset; bytes beyond the line end shift in as zero.
    function automatic logic [63:0] extract(input logic [511:0] line, input logic [5:0] off);
        logic [511:0] shifted;
        shifted = line >> {off, 3'b000};
        return shifted[63:0];
    endfunction

    // Overlay the low size bytes of data at the offset; bytes shifted past the line are lost.
    function automatic logic [511:0] merge(input logic [511:0] line, input logic [5:0] off,
                                           input logic [63:0] data, input logic [3:0] size);
        logic [7:0]   byte_en;
        logic [511:0] mask;
        logic [511:0] data_shift;
        case (size)
            4'd1:    byte_en = 8'h01;
            4'd2:    byte_en = 8'h03;
            4'd4:    byte_en = 8'h0F;
            default: byte_en = 8'hFF;
        endcase
        mask = '0;
        for (int j = 0; j < 8; j++) begin
            mask[8*j +: 8] = {8{byte_en[j]}};
        end
        mask       = mask << {off, 3'b000};
        data_shift = {448'b0, data} << {off, 3'b000};
        return (line & ~mask) | (data_shift & mask);
    endfunction

    logic [5:0]   r_idx, w_idx, f_idx, s_idx;
    logic [51:0]  r_tag, w_tag, f_tag, s_tag;
    logic         r_hit, w_hit, fill_now, snoop_kill;
    logic [511:0] merged_hit, merged_fill;
    logic         unused_snoop_bits;

    assign r_idx = bus.S_R_ADDR[11:6];
    assign r_tag = bus.S_R_ADDR[63:12];
    assign w_idx = bus.S_W_ADDR[11:6];
    assign w_tag = bus.S_W_ADDR[63:12];
    assign f_idx = addr_reg[11:6];
    assign f_tag = addr_reg[63:12];
    assign s_idx = bus.m_axi_acaddr[11:6];
    assign s_tag = bus.m_axi_acaddr[63:12];
    assign unused_snoop_bits = ^bus.m_axi_acaddr[5:0];

    assign r_hit    = valid_reg[r_idx] && (tag_mem[r_idx] == r_tag);
    assign w_hit    = valid_reg[w_idx] && (tag_mem[w_idx] == w_tag);
    assign fill_now = ((state_reg == RD_FILL) || (state_reg == WR_FILL)) && bus.L2_S_R_DATA_VALID;

    // A snoop aimed at the set being filled is judged against the incoming tag so it can kill it.
    assign snoop_kill = bus.m_axi_acvalid && (bus.m_axi_acsnoop == MAKE_INVALID) &&
                        ((fill_now && (s_idx == f_idx)) ? (s_tag == f_tag)
                                                        : (valid_reg[s_idx] && (tag_mem[s_idx] == s_tag)));

    assign merged_hit  = merge(data_mem[w_idx], bus.S_W_ADDR[5:0], bus.S_W_DATA, bus.S_W_SIZE);
    assign merged_fill = merge(bus.L2_S_R_DATA, addr_reg[5:0], wdata_reg, wsize_reg);

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (fill_now) begin
                data_mem[f_idx] <= bus.L2_S_R_DATA;
                tag_mem[f_idx]  <= f_tag;
            end else if (state_reg == WR_SEND) begin
                data_mem[f_idx] <= bus.L2_S_W_DATA;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg             <= IDLE;
            valid_reg             <= '0;
            addr_reg              <= '0;
            wdata_reg             <= '0;
            wsize_reg             <= '0;
            bus.S_R_DATA          <= '0;
            bus.S_R_DATA_VALID    <= 1'b0;
            bus.S_W_READY         <= 1'b1;
            bus.S_W_COMPLETE      <= 1'b0;
            bus.L2_S_R_ADDR       <= '0;
            bus.L2_S_R_ADDR_VALID <= 1'b0;
            bus.L2_S_W_VALID      <= 1'b0;
            bus.L2_S_W_ADDR       <= '0;
            bus.L2_S_W_DATA       <= '0;
        end else begin
            bus.S_R_DATA_VALID <= 1'b0;
            bus.S_W_COMPLETE   <= 1'b0;
            if (fill_now) begin
                valid_reg[f_idx] <= 1'b1;
            end
            if (snoop_kill) begin
                valid_reg[s_idx] <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (bus.S_R_ADDR_VALID) begin
                        if (r_hit) begin
                            bus.S_R_DATA       <= extract(data_mem[r_idx], bus.S_R_ADDR[5:0]);
                            bus.S_R_DATA_VALID <= 1'b1;
                        end else begin
                            addr_reg              <= bus.S_R_ADDR;
                            bus.L2_S_R_ADDR       <= {bus.S_R_ADDR[63:6], 6'b0};
                            bus.L2_S_R_ADDR_VALID <= 1'b1;
                            bus.S_W_READY         <= 1'b0;
                            state_reg             <= RD_FILL;
                        end
                    end else if (bus.S_W_VALID && bus.S_W_READY) begin
                        addr_reg      <= bus.S_W_ADDR;
                        wdata_reg     <= bus.S_W_DATA;
                        wsize_reg     <= bus.S_W_SIZE;
                        bus.S_W_READY <= 1'b0;
                        if (w_hit) begin
                            bus.L2_S_W_ADDR  <= {bus.S_W_ADDR[63:6], 6'b0};
                            bus.L2_S_W_DATA  <= merged_hit;
                            bus.L2_S_W_VALID <= 1'b1;
                            state_reg        <= WR_SEND;
                        end else begin
                            bus.L2_S_R_ADDR       <= {bus.S_W_ADDR[63:6], 6'b0};
                            bus.L2_S_R_ADDR_VALID <= 1'b1;
                            state_reg             <= WR_FILL;
                        end
                    end
                end
                RD_FILL: begin
                    if (bus.L2_S_R_DATA_VALID) begin
                        bus.L2_S_R_ADDR_VALID <= 1'b0;
                        bus.S_R_DATA          <= extract(bus.L2_S_R_DATA, addr_reg[5:0]);
                        bus.S_R_DATA_VALID    <= 1'b1;
                        state_reg             <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    bus.S_W_READY <= 1'b1;
                    state_reg     <= IDLE;
                end
                WR_FILL: begin
                    if (bus.L2_S_R_DATA_VALID) begin
                        bus.L2_S_R_ADDR_VALID <= 1'b0;
                        bus.L2_S_W_ADDR       <= {addr_reg[63:6], 6'b0};
                        bus.L2_S_W_DATA       <= merged_fill;
                        bus.L2_S_W_VALID      <= 1'b1;
                        state_reg             <= WR_SEND;
                    end
                end
                WR_SEND: begin
                    if (bus.L2_S_W_READY) begin
                        bus.L2_S_W_VALID <= 1'b0;
                        state_reg        <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (bus.L2_S_W_COMPLETE) begin
                        bus.S_W_COMPLETE <= 1'b1;
                        state_reg        <= WR_DONE;
                    end
                end
                WR_DONE: begin
                    bus.S_W_READY <= 1'b1;
                    state_reg     <= IDLE;
                end
                default: begin
                    bus.S_W_READY <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_l1_d.sv
// Randomized bench for l1_d: a byte-level LLC image plus per-set valid/tag model predicts
// hits, fill/write-through traffic, latencies and load data.
module tb_l1_d;
    logic clk = 1'b0;
    logic reset = 1'b1;

    l1_d_if bus();

    l1_d dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: LLC image by line address, and the cache's valid/tag per set.
    logic [511:0] llc [logic [57:0]];
    bit           m_valid [64];
    logic [51:0]  m_tag [64];

    function automatic logic [511:0] line_of(input logic [57:0] la);
        logic [511:0] l;
        if (llc.exists(la)) return llc[la];
        for (int i = 0; i < 64; i++) l[8*i +: 8] = 8'(i + 13 * (int'(la[31:0]) - 64));
        return l;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] a);
        logic [511:0] l;
        logic [63:0]  r;
        int           off;
        l   = line_of(a[63:6]);
        r   = '0;
        off = int'(a[5:0]);
        for (int j = 0; j < 8; j++) if (off + j < 64) r[8*j +: 8] = l[8*(off+j) +: 8];
        return r;
    endfunction

    function automatic logic [511:0] model_merge(input logic [511:0] l, input logic [63:0] a,
                                                 input logic [63:0] d, input logic [3:0] sz);
        int n, off;
        n   = (sz == 4'd1 || sz == 4'd2 || sz == 4'd4) ? int'(sz) : 8;
        off = int'(a[5:0]);
        for (int j = 0; j < n; j++) if (off + j < 64) l[8*(off+j) +: 8] = d[8*j +: 8];
        return l;
    endfunction

    function automatic bit model_hit(input logic [63:0] a);
        return m_valid[a[11:6]] && (m_tag[a[11:6]] == a[63:12]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        bus.L2_S_R_DATA_VALID = 1'b0;
        bus.L2_S_W_READY      = 1'b0;
        bus.L2_S_W_COMPLETE   = 1'b0;
        bus.m_axi_acvalid     = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.S_W_READY !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("idle_reached", bus.S_W_READY, 1'b1);
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_rvalid"},  bus.S_R_DATA_VALID, 1'b0);
        check({p, "_rdata"},   bus.S_R_DATA, 64'h0);
        check({p, "_wready"},  bus.S_W_READY, 1'b1);
        check({p, "_wcmp"},    bus.S_W_COMPLETE, 1'b0);
        check({p, "_l2rv"},    bus.L2_S_R_ADDR_VALID, 1'b0);
        check({p, "_l2ra"},    bus.L2_S_R_ADDR, 64'h0);
        check({p, "_l2wv"},    bus.L2_S_W_VALID, 1'b0);
        check({p, "_l2wa"},    bus.L2_S_W_ADDR, 64'h0);
        check({p, "_l2wd"},    bus.L2_S_W_DATA, 512'h0);
    endtask

    task automatic do_load(input logic [63:0] a, input bit snoop_fill, output logic [63:0] data);
        bit exp_hit;
        bit got = 1'b0;
        int cycles = 0;
        int fill_cycle = -1;
        int first_l2 = -1;
        int delay;
        data = '0;
        wait_idle();
        exp_hit = model_hit(a);
        delay   = int'($urandom_range(0, 3));
        bus.S_R_ADDR       = a;
        bus.S_R_ADDR_VALID = 1'b1;
        while (!got && cycles < 40) begin
            tick();
            cycles++;
            if (bus.S_R_DATA_VALID) begin
                got  = 1'b1;
                data = bus.S_R_DATA;
                bus.S_R_ADDR_VALID = 1'b0;
            end else if (bus.L2_S_R_ADDR_VALID && fill_cycle < 0) begin
                if (first_l2 < 0) begin
                    first_l2 = cycles;
                    check("ld_fill_addr", bus.L2_S_R_ADDR, {a[63:6], 6'b0});
                end
                if (delay == 0) begin
                    bus.L2_S_R_DATA       = line_of(a[63:6]);
                    bus.L2_S_R_DATA_VALID = 1'b1;
                    fill_cycle = cycles;
                    if (snoop_fill) begin
                        bus.m_axi_acvalid = 1'b1;
                        bus.m_axi_acaddr  = {a[63:6], 6'h20};
                        bus.m_axi_acsnoop = 4'b1101;
                    end
                end else begin
                    delay--;
                end
            end
        end
        bus.S_R_ADDR_VALID = 1'b0;
        check("ld_done", got, 1'b1);
        check("ld_hit", (fill_cycle < 0), exp_hit);
        if (exp_hit) begin
            check("ld_hit_lat", cycles, 1);
        end else begin
            check("ld_req_lat", first_l2, 1);
            check("ld_miss_lat", cycles, fill_cycle + 1);
            m_valid[a[11:6]] = !snoop_fill;
            m_tag[a[11:6]]   = a[63:12];
        end
        check("ld_data", data, model_load(a));
        $display("load  addr=%h hit=%0d data=%h", a, exp_hit, data);
    endtask

    task automatic do_store(input logic [63:0] a, input logic [63:0] d, input logic [3:0] sz,
                            input int rd, input int cd, input bit snoop_fill);
        bit           exp_hit;
        bit           done = 1'b0;
        logic [511:0] exp_line;
        int cycles = 0;
        int fill_cycle = -1;
        int comp_cycle = -1;
        int wv = 0;
        int fdelay;
        int cdel;
        wait_idle();
        exp_hit  = model_hit(a);
        exp_line = model_merge(line_of(a[63:6]), a, d, sz);
        fdelay   = int'($urandom_range(0, 3));
        cdel     = cd;
        bus.S_W_ADDR  = a;
        bus.S_W_DATA  = d;
        bus.S_W_SIZE  = sz;
        bus.S_W_VALID = 1'b1;
        while (!done && cycles < 80) begin
            tick();
            cycles++;
            if (cycles == 1) begin
                bus.S_W_VALID = 1'b0;
                check("st_ready_low", bus.S_W_READY, 1'b0);
            end
            if (bus.S_W_COMPLETE) begin
                done = 1'b1;
                check("st_cmp_lat", cycles, comp_cycle + 1);
            end else if (bus.L2_S_R_ADDR_VALID && fill_cycle < 0) begin
                if (fdelay == 0) begin
                    check("st_fill_addr", bus.L2_S_R_ADDR, {a[63:6], 6'b0});
                    bus.L2_S_R_DATA       = line_of(a[63:6]);
                    bus.L2_S_R_DATA_VALID = 1'b1;
                    fill_cycle = cycles;
                    if (snoop_fill) begin
                        bus.m_axi_acvalid = 1'b1;
                        bus.m_axi_acaddr  = a;
                        bus.m_axi_acsnoop = 4'b1101;
                    end
                end else begin
                    fdelay--;
                end
            end else if (bus.L2_S_W_VALID) begin
                wv++;
                if (wv == 1) begin
                    check("st_w_addr", bus.L2_S_W_ADDR, {a[63:6], 6'b0});
                    check("st_w_data", bus.L2_S_W_DATA, exp_line);
                end
                if (wv > rd) bus.L2_S_W_READY = 1'b1;
            end else if (wv > 0 && comp_cycle < 0) begin
                if (cdel == 0) begin
                    bus.L2_S_W_COMPLETE = 1'b1;
                    comp_cycle = cycles;
                end else begin
                    cdel--;
                end
            end
        end
        check("st_done", done, 1'b1);
        check("st_hit", (fill_cycle < 0), exp_hit);
        check("st_w_hold", wv, rd + 1);
        llc[a[63:6]] = exp_line;
        if (!exp_hit) begin
            m_valid[a[11:6]] = !snoop_fill;
            m_tag[a[11:6]]   = a[63:12];
        end
        $display("store addr=%h size=%0d data=%h hit=%0d", a, sz, d, exp_hit);
    endtask

    task automatic do_snoop(input logic [63:0] a, input logic [3:0] typ);
        bus.m_axi_acvalid = 1'b1;
        bus.m_axi_acaddr  = a;
        bus.m_axi_acsnoop = typ;
        tick();
        if (typ == 4'b1101 && model_hit(a)) m_valid[a[11:6]] = 1'b0;
        $display("snoop addr=%h type=%b", a, typ);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] rd_data;
        logic [63:0] a;
        logic [3:0]  sz;
        int          n;
        bus.S_R_ADDR = '0;          bus.S_R_ADDR_VALID = 1'b0;
        bus.S_W_VALID = 1'b0;       bus.S_W_ADDR = '0;
        bus.S_W_DATA = '0;          bus.S_W_SIZE = '0;
        bus.L2_S_R_DATA = '0;       bus.L2_S_R_DATA_VALID = 1'b0;
        bus.L2_S_W_READY = 1'b0;    bus.L2_S_W_COMPLETE = 1'b0;
        bus.m_axi_acvalid = 1'b0;   bus.m_axi_acaddr = '0;
        bus.m_axi_acsnoop = '0;
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
        repeat (3) tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();

        do_load(64'h1008, 1'b0, rd_data);
        check("plan_cold_load", rd_data, 64'h0F0E0D0C0B0A0908);
        do_load(64'h1008, 1'b0, rd_data);
        do_store(64'h1010, 64'h1234_5678_9ABC_BEEF, 4'd2, 3, 2, 1'b0);
        do_load(64'h1010, 1'b0, rd_data);
        check("plan_beef", rd_data[15:0], 16'hBEEF);
        do_load(64'h103C, 1'b0, rd_data);
        check("line_end_zero", rd_data[63:32], 32'h0);
        do_store(64'h2040, 64'hCAFE_F00D_0123_4567, 4'd8, 0, 0, 1'b0);
        do_snoop(64'h1020, 4'b1101);
        do_load(64'h1008, 1'b0, rd_data);
        do_snoop(64'h2040, 4'b0000);
        do_load(64'h2040, 1'b0, rd_data);
        do_load(64'h3100, 1'b1, rd_data);
        do_load(64'h3100, 1'b0, rd_data);
        do_store(64'h5139, 64'hA5A5_5A5A_DEAD_BEEF, 4'd8, 1, 1, 1'b1);
        do_load(64'h5138, 1'b0, rd_data);

        // Reset while a fill is outstanding.
        wait_idle();
        bus.S_R_ADDR       = 64'h7_0180;
        bus.S_R_ADDR_VALID = 1'b1;
        n = 0;
        while (!bus.L2_S_R_ADDR_VALID && n < 5) begin
            tick();
            n++;
        end
        check("rf_fill_seen", bus.L2_S_R_ADDR_VALID, 1'b1);
        reset = 1'b1;
        bus.S_R_ADDR_VALID = 1'b0;
        tick();
        check_reset_outputs("rst_mid");
        reset = 1'b0;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        tick();
        do_load(64'h1008, 1'b0, rd_data);

        for (int k = 0; k < 60; k++) begin
            a = 64'h4000_0000 | (64'($urandom_range(0, 3)) << 12) |
                (64'($urandom_range(0, 7)) << 6) | 64'($urandom_range(0, 63));
            case ($urandom_range(0, 7))
                0: sz = 4'd1;
                1: sz = 4'd2;
                2: sz = 4'd4;
                3: sz = 4'd8;
                4: sz = 4'd3;
                5: sz = 4'd0;
                6: sz = 4'd15;
                default: sz = 4'd8;
            endcase
            case ($urandom_range(0, 9))
                0, 1, 2, 3: do_load(a, 1'b0, rd_data);
                4, 5, 6, 7: do_store(a, {$urandom, $urandom}, sz,
                                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
                8:          do_snoop(a, 4'b1101);
                default:    do_snoop(a, 4'($urandom_range(0, 12)));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
